// File: rtl/rgbw_frame_scheduler.sv
// rgbw_frame_scheduler
// Receive-side frame parser for the RGBW light engine. Bytes arrive from the
// SPI slave as a level "rdy" (asynchronous to clk) plus a data byte. A frame
// is the sync byte 0x55 followed by 7 payload bytes (lint, colorIdx, red,
// green, blue, white, mode). A complete frame is held until the next PWM
// period boundary and then committed to all outputs in one edge.
//
// Optional build macro: CHECKSUM_EN -- the frame carries an 8th payload byte
// equal to the mod-256 sum of the 7 payload bytes; mismatches are rejected.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   rdy, buffRx_spi       byte-ready level and received byte from SPI slave
//   period_end            one-cycle PWM period boundary strobe
//   *_sync (7 x 8 bit)    committed frame values
//   upd_pulse             high in the first cycle new values are visible
//   frame_err             one-cycle strobe on timeout, overrun or bad checksum
//   busy                  high while a frame is being received or is pending
module rgbw_frame_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rdy,
    input  logic [7:0] buffRx_spi,
    input  logic       period_end,
    output logic [7:0] lint_sync,
    output logic [7:0] colorIdx_sync,
    output logic [7:0] red_sync,
    output logic [7:0] green_sync,
    output logic [7:0] blue_sync,
    output logic [7:0] white_sync,
    output logic [7:0] mode_sync,
    output logic       upd_pulse,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_RECV = 2'd1,
`ifdef CHECKSUM_EN
        ST_CHK  = 2'd2,
`endif
        ST_PEND = 2'd3
    } state_t;

    localparam logic [7:0]      SYNC_BYTE = 8'h55;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef CHECKSUM_EN
    // Mod-256 sum of the seven staged payload bytes.
    function automatic logic [7:0] sum7(input logic [55:0] flat);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 7; i++) begin
            acc = acc + flat[i*8 +: 8];
        end
        return acc;
    endfunction
`endif

    logic            rdy_sync1_r, rdy_sync2_r, rdy_sync3_r;
    logic            bev_s;
    state_t          state_r, state_nxt_s;
    logic [2:0]      idx_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [7:0]      stage_r [7];
    logic            store_s, err_s, commit_s, discard_s, timeout_s;

    // Two-flop synchroniser for rdy plus a third flop for rise detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_sync1_r <= 1'b0;
            rdy_sync2_r <= 1'b0;
            rdy_sync3_r <= 1'b0;
        end else begin
            rdy_sync1_r <= rdy;
            rdy_sync2_r <= rdy_sync1_r;
            rdy_sync3_r <= rdy_sync2_r;
        end
    end

    assign bev_s     = rdy_sync2_r & ~rdy_sync3_r;
    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout_s = (to_cnt_r == TO_LAST) && !bev_s;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_nxt_s = state_r;
        store_s     = 1'b0;
        err_s       = 1'b0;
        commit_s    = 1'b0;
        discard_s   = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (bev_s && (buffRx_spi == SYNC_BYTE)) begin
                    state_nxt_s = ST_RECV;
                end else begin
                    state_nxt_s = ST_HUNT;
                end
            end
            ST_RECV: begin
                if (bev_s) begin
                    store_s = 1'b1;
                    if (idx_r == 3'd6) begin
`ifdef CHECKSUM_EN
                        state_nxt_s = ST_CHK;
`else
                        state_nxt_s = ST_PEND;
`endif
                    end else begin
                        state_nxt_s = ST_RECV;
                    end
                end else if (timeout_s) begin
                    err_s       = 1'b1;
                    discard_s   = 1'b1;
                    state_nxt_s = ST_HUNT;
                end else begin
                    state_nxt_s = ST_RECV;
                end
            end
`ifdef CHECKSUM_EN
            ST_CHK: begin
                if (bev_s) begin
                    if (buffRx_spi == sum7({stage_r[6], stage_r[5], stage_r[4], stage_r[3],
                                            stage_r[2], stage_r[1], stage_r[0]})) begin
                        state_nxt_s = ST_PEND;
                    end else begin
                        err_s       = 1'b1;
                        discard_s   = 1'b1;
                        state_nxt_s = ST_HUNT;
                    end
                end else if (timeout_s) begin
                    err_s       = 1'b1;
                    discard_s   = 1'b1;
                    state_nxt_s = ST_HUNT;
                end else begin
                    state_nxt_s = ST_CHK;
                end
            end
`endif
            ST_PEND: begin
                // Overrun byte is dropped; the pending frame still commits.
                if (bev_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
                if (period_end) begin
                    commit_s    = 1'b1;
                    state_nxt_s = ST_HUNT;
                end else begin
                    state_nxt_s = ST_PEND;
                end
            end
            default: begin
                state_nxt_s = ST_HUNT;
            end
        endcase
    end

    // Inter-byte timeout counter: idle outside RECV/CHK, cleared by every byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_r <= '0;
        end else if ((state_r == ST_HUNT) || (state_r == ST_PEND) || bev_s) begin
            to_cnt_r <= '0;
        end else if (to_cnt_r != TO_LAST) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_r <= to_cnt_r;
        end
    end

    // Payload index and staging registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r <= 3'd0;
            for (int i = 0; i < 7; i++) stage_r[i] <= 8'h00;
        end else begin
            if (state_r == ST_HUNT) begin
                idx_r <= 3'd0;
            end else if (store_s) begin
                idx_r <= idx_r + 3'd1;
            end else begin
                idx_r <= idx_r;
            end
            for (int i = 0; i < 7; i++) begin
                if (discard_s) begin
                    stage_r[i] <= 8'h00;
                end else if (store_s && (idx_r == 3'(i))) begin
                    stage_r[i] <= buffRx_spi;
                end else begin
                    stage_r[i] <= stage_r[i];
                end
            end
        end
    end

    // Committed outputs and status strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lint_sync     <= 8'h00;
            colorIdx_sync <= 8'h00;
            red_sync      <= 8'h00;
            green_sync    <= 8'h00;
            blue_sync     <= 8'h00;
            white_sync    <= 8'h00;
            mode_sync     <= 8'h00;
            upd_pulse     <= 1'b0;
            frame_err     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            if (commit_s) begin
                lint_sync     <= stage_r[0];
                colorIdx_sync <= stage_r[1];
                red_sync      <= stage_r[2];
                green_sync    <= stage_r[3];
                blue_sync     <= stage_r[4];
                white_sync    <= stage_r[5];
                mode_sync     <= stage_r[6];
            end else begin
                lint_sync     <= lint_sync;
                colorIdx_sync <= colorIdx_sync;
                red_sync      <= red_sync;
                green_sync    <= green_sync;
                blue_sync     <= blue_sync;
                white_sync    <= white_sync;
                mode_sync     <= mode_sync;
            end
            upd_pulse <= commit_s;
            frame_err <= err_s;
            busy      <= (state_nxt_s != ST_HUNT);
        end
    end

endmodule

// File: tb/tb_rgbw_frame_scheduler.sv
// Directed self-checking bench for rgbw_frame_scheduler.
module tb_rgbw_frame_scheduler;

    logic       clk;
    logic       reset;
    logic       rdy;
    logic [7:0] buffRx_spi;
    logic       period_end;
    logic [7:0] lint_sync, colorIdx_sync, red_sync, green_sync;
    logic [7:0] blue_sync, white_sync, mode_sync;
    logic       upd_pulse, frame_err, busy;

    logic [55:0] outs_s;
    int          n_cmp;
    int          n_bad;
    int          upd_cnt;
    int          err_cnt;
    int          err_base;
    int          upd_base;

    localparam logic [55:0] F1 = 56'h10_02_80_40_20_FF_01;
    localparam logic [55:0] F2 = 56'h21_22_23_24_25_26_27;
    localparam logic [55:0] F3 = 56'h31_32_33_34_35_36_37;
    localparam logic [55:0] F4 = 56'h41_55_43_44_45_46_47;

    rgbw_frame_scheduler #(.TIMEOUT_CYCLES(4096), .TO_W(13)) dut (
        .clk           (clk),
        .reset         (reset),
        .rdy           (rdy),
        .buffRx_spi    (buffRx_spi),
        .period_end    (period_end),
        .lint_sync     (lint_sync),
        .colorIdx_sync (colorIdx_sync),
        .red_sync      (red_sync),
        .green_sync    (green_sync),
        .blue_sync     (blue_sync),
        .white_sync    (white_sync),
        .mode_sync     (mode_sync),
        .upd_pulse     (upd_pulse),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    assign outs_s = {lint_sync, colorIdx_sync, red_sync, green_sync,
                     blue_sync, white_sync, mode_sync};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (upd_pulse) upd_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        buffRx_spi = b;
        rdy        = 1'b1;
        repeat (6) @(negedge clk);
        rdy = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Sync byte, optional stall, 7 payload bytes (+ checksum when enabled).
    task automatic send_frame(input logic [55:0] f, input int stall);
        logic [7:0] sum;
        sum = 8'h00;
        send_byte(8'h55);
        repeat (stall) @(negedge clk);
        for (int i = 6; i >= 0; i--) begin
            send_byte(f[i*8 +: 8]);
            sum = sum + f[i*8 +: 8];
        end
`ifdef CHECKSUM_EN
        send_byte(sum);
`endif
    endtask

    // One-cycle period_end; leaves the bench at the negedge after the commit edge.
    task automatic pulse_pe();
        @(negedge clk);
        period_end = 1'b1;
        @(negedge clk);
        period_end = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        upd_cnt    = 0;
        err_cnt    = 0;
        rdy        = 1'b0;
        buffRx_spi = 8'h00;
        period_end = 1'b0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_outs", {8'h00, outs_s}, 64'h0);
        check_eq("rst_flags", {61'h0, upd_pulse, frame_err, busy}, 64'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: basic frame, held until period_end
        send_frame(F1, 0);
        repeat (20) @(negedge clk);
        check_eq("t1_hold_outs", {8'h00, outs_s}, 64'h0);
        check_eq("t1_busy_pend", {63'h0, busy}, 64'h1);
        check_eq("t1_no_upd", 64'(upd_cnt), 64'd0);
        pulse_pe();
        check_eq("t1_upd_hi", {63'h0, upd_pulse}, 64'h1);
        check_eq("t1_outs", {8'h00, outs_s}, {8'h00, F1});
        @(negedge clk);
        check_eq("t1_upd_lo", {63'h0, upd_pulse}, 64'h0);
        check_eq("t1_busy_lo", {63'h0, busy}, 64'h0);
        check_eq("t1_upd_cnt", 64'(upd_cnt), 64'd1);
        check_eq("t1_no_err", 64'(err_cnt), 64'd0);

        // 2: junk ignored in HUNT, then a frame
        send_byte(8'hAA);
        send_byte(8'h13);
        check_eq("t2_busy_junk", {63'h0, busy}, 64'h0);
        send_frame(F2, 0);
        pulse_pe();
        check_eq("t2_outs", {8'h00, outs_s}, {8'h00, F2});
        check_eq("t2_no_err", 64'(err_cnt), 64'd0);

        // 3: timeout mid-frame
        err_base = err_cnt;
        send_byte(8'h55);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (4200) @(negedge clk);
        check_eq("t3_err_once", 64'(err_cnt - err_base), 64'd1);
        check_eq("t3_busy_lo", {63'h0, busy}, 64'h0);
        check_eq("t3_outs_kept", {8'h00, outs_s}, {8'h00, F2});
        send_frame(F3, 0);
        pulse_pe();
        check_eq("t3_next_outs", {8'h00, outs_s}, {8'h00, F3});

        // 3b: gap just under the limit does not abort; inner 0x55 is payload
        err_base = err_cnt;
        send_frame(F4, 4000);
        pulse_pe();
        check_eq("t3b_no_err", 64'(err_cnt - err_base), 64'd0);
        check_eq("t3b_outs", {8'h00, outs_s}, {8'h00, F4});

        // 4: overrun in PEND
        err_base = err_cnt;
        send_frame(F1, 0);
        send_byte(8'h77);
        check_eq("t4_err", 64'(err_cnt - err_base), 64'd1);
        check_eq("t4_busy", {63'h0, busy}, 64'h1);
        check_eq("t4_outs_kept", {8'h00, outs_s}, {8'h00, F4});
        pulse_pe();
        check_eq("t4_outs", {8'h00, outs_s}, {8'h00, F1});

        // 5: reset while pending
        send_frame(F2, 0);
        check_eq("t5_busy_pend", {63'h0, busy}, 64'h1);
        upd_base = upd_cnt;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t5_outs_zero", {8'h00, outs_s}, 64'h0);
        check_eq("t5_busy_lo", {63'h0, busy}, 64'h0);
        reset = 1'b0;
        pulse_pe();
        repeat (10) @(negedge clk);
        check_eq("t5_no_upd", 64'(upd_cnt - upd_base), 64'd0);
        check_eq("t5_outs_still0", {8'h00, outs_s}, 64'h0);

`ifdef CHECKSUM_EN
        // 6: checksum good then bad
        send_frame(56'h01_02_03_04_05_06_07, 0);
        pulse_pe();
        check_eq("t6_good_outs", {8'h00, outs_s}, 64'h0001_0203_0405_0607);
        err_base = err_cnt;
        upd_base = upd_cnt;
        send_byte(8'h55);
        for (int i = 1; i <= 7; i++) send_byte(8'(i));
        send_byte(8'h1D);
        check_eq("t6_bad_err", 64'(err_cnt - err_base), 64'd1);
        check_eq("t6_bad_busy", {63'h0, busy}, 64'h0);
        pulse_pe();
        repeat (4) @(negedge clk);
        check_eq("t6_bad_no_upd", 64'(upd_cnt - upd_base), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
